uart_boot_ctrl: RTL and testbench

Framed software-upgrade controller that sequences UART-based RAM loading. It parses a framed byte stream from the UART receiver: sync byte, little-endian word count, payload, then checksum. It assembles payload bytes into XLEN words and writes them to instruction/data RAM. It owns the RAM port during an upgrade, arbitrating it away from the core, holds the core in reset while loading, and reports done or error status.

---
 rtl/uart_boot_ctrl_if.sv | 12 +
 rtl/uart_boot_ctrl.sv | 128 ++++++++++++
 tb/tb_uart_boot_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_boot_ctrl_if.sv
// uart_boot_ctrl_if: word-addressed RAM port with byte write enables
interface uart_boot_ctrl_if #(
  parameter int ADDR_LEN = 14,
  parameter int XLEN = 32
) ();
  logic en;
  logic [XLEN/8-1:0] we;
  logic [ADDR_LEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  modport master (output en, we, addr, wdata);
  modport slave (input en, we, addr, wdata);
endinterface

// File: rtl/uart_boot_ctrl.sv
// uart_boot_ctrl: framed UART loader that writes RAM words and holds the core in reset while loading
module uart_boot_ctrl #(
  parameter int ADDR_LEN = 14,
  parameter int XLEN = 32,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rstb,
  input  logic upgrade_req_b_i,
  input  logic uart_rx_valid_i,
  input  logic [7:0] uart_rx_data_i,
  uart_boot_ctrl_if.slave core_i,
  uart_boot_ctrl_if.master ram_o,
  output logic core_rstb_o,
  output logic busy_o,
  output logic done_o,
  output logic [1:0] err_o
);
  localparam int BPW = XLEN / 8;
  localparam int LW = BPW > 1 ? $clog2(BPW) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [16:0] LIM = 17'd1 << ADDR_LEN;
  localparam logic [LW-1:0] LAST = LW'(BPW - 1);
  typedef enum logic [2:0] {IDLE, SYNC, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;
  state_t state_q;
  logic [15:0] len_q;
  logic [16:0] cnt_q;
  logic [ADDR_LEN-1:0] addr_q;
  logic [LW-1:0] lane_q;
  logic [XLEN-1:0] word_q;
  logic [7:0] sum_q;
  logic [TW-1:0] to_q;
  logic wr_q, core_rstb_q, done_q;
  logic [1:0] err_q;
  logic rx, timed, tmo, last_wr, csum_byte;
  logic [7:0] sum_d;
  logic [16:0] len_d;
  assign rx = uart_rx_valid_i;
  assign timed = state_q inside {LEN0, LEN1, DATA, CSUM};
  assign tmo = timed && !rx && to_q == TW'(TIMEOUT_CYC - 1);
  // the final word's write cycle doubles as the CSUM cycle so back-to-back bytes are not lost
  assign last_wr = wr_q && cnt_q + 17'd1 == {1'b0, len_q};
  assign csum_byte = rx && (state_q == CSUM || (state_q == DATA && last_wr));
  assign sum_d = sum_q + uart_rx_data_i;
  assign len_d = {1'b0, uart_rx_data_i, len_q[7:0]};
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      state_q <= IDLE;
      len_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      lane_q <= '0;
      word_q <= '0;
      sum_q <= '0;
      to_q <= '0;
      wr_q <= 1'b0;
      core_rstb_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 2'd0;
    end else begin
      wr_q <= 1'b0;
      if (wr_q) begin
        addr_q <= addr_q + 1'b1;
        cnt_q <= cnt_q + 17'd1;
      end
      if (timed) to_q <= rx ? '0 : to_q + 1'b1;
      if (timed && rx) sum_q <= sum_d;
      case (state_q)
        IDLE: begin
          core_rstb_q <= upgrade_req_b_i;
          if (!upgrade_req_b_i) begin
            state_q <= SYNC;
            done_q <= 1'b0;
            err_q <= 2'd0;
            addr_q <= '0;
            cnt_q <= '0;
            lane_q <= '0;
            sum_q <= '0;
            to_q <= '0;
          end
        end
        SYNC: if (rx && uart_rx_data_i == SYNC_BYTE) state_q <= LEN0;
        LEN0: if (rx) begin
          len_q[7:0] <= uart_rx_data_i;
          state_q <= LEN1;
        end
        LEN1: if (rx) begin
          len_q[15:8] <= uart_rx_data_i;
          state_q <= len_d > LIM ? ERR : len_d == '0 ? CSUM : DATA;
          if (len_d > LIM) err_q <= 2'd2;
        end
        DATA: begin
          if (last_wr) state_q <= CSUM;
          if (rx && !last_wr) begin
            word_q[lane_q*8 +: 8] <= uart_rx_data_i;
            lane_q <= lane_q == LAST ? '0 : lane_q + 1'b1;
            wr_q <= lane_q == LAST;
          end
        end
        DONE: if (upgrade_req_b_i) state_q <= IDLE;
        ERR: if (upgrade_req_b_i) begin
          state_q <= IDLE;
          core_rstb_q <= 1'b1;
        end
        default: ;
      endcase
      if (csum_byte) begin
        state_q <= sum_d == 8'h00 ? DONE : ERR;
        done_q <= sum_d == 8'h00;
        core_rstb_q <= sum_d == 8'h00;
        if (sum_d != 8'h00) err_q <= 2'd1;
      end
      if (tmo) begin
        state_q <= ERR;
        err_q <= 2'd3;
        lane_q <= '0;
      end
    end
  assign busy_o = !(state_q inside {IDLE, DONE});
  assign core_rstb_o = core_rstb_q;
  assign done_o = done_q;
  assign err_o = err_q;
  assign ram_o.en = busy_o ? wr_q : core_i.en;
  assign ram_o.we = busy_o ? {BPW{wr_q}} : core_i.we;
  assign ram_o.addr = busy_o ? addr_q : core_i.addr;
  assign ram_o.wdata = busy_o ? word_q : core_i.wdata;
endmodule

// File: tb/tb_uart_boot_ctrl.sv
// tb_uart_boot_ctrl: frame table plus hand-written corner sequences, RAM writes checked via scoreboard
module tb_uart_boot_ctrl;
  typedef struct {
    string name;
    int n;
    int gap;
    logic [7:0] b [72];
    logic [1:0] err;
    logic done;
  } vec_t;
  logic clk, rstb, req_b, rx_v;
  logic [7:0] rx_d;
  logic core_rstb, busy, done;
  logic [1:0] err;
  int total = 0, passed = 0;
  logic [35:0] exp_q[$];
  vec_t tbl[$];
  vec_t v;
  uart_boot_ctrl_if #(.ADDR_LEN(4), .XLEN(32)) core_if ();
  uart_boot_ctrl_if #(.ADDR_LEN(4), .XLEN(32)) ram_if ();
  uart_boot_ctrl #(.ADDR_LEN(4), .XLEN(32), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rstb(rstb), .upgrade_req_b_i(req_b), .uart_rx_valid_i(rx_v), .uart_rx_data_i(rx_d),
    .core_i(core_if), .ram_o(ram_if), .core_rstb_o(core_rstb), .busy_o(busy), .done_o(done), .err_o(err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    rx_v = 1'b1;
    rx_d = b;
    tick(1);
    rx_v = 1'b0;
  endtask
  task automatic add(input string nm, input int gap, input logic [1:0] e, input logic d, input logic [95:0] p, input int n);
    vec_t t;
    t.name = nm;
    t.n = n;
    t.gap = gap;
    t.err = e;
    t.done = d;
    for (int i = 0; i < 72; i++) t.b[i] = 8'h00;
    for (int i = 0; i < n; i++) t.b[i] = p[8*(n-1-i) +: 8];
    tbl.push_back(t);
  endtask
  task automatic push_frame(input vec_t f);
    int s = 0;
    int len;
    while (s < f.n && f.b[s] != 8'hA5) s++;
    if (s + 2 >= f.n) return;
    len = int'({f.b[s+2], f.b[s+1]});
    if (len > 16) return;
    for (int w = 0; w < len && s + 6 + 4*w < f.n; w++)
      exp_q.push_back({4'(w), f.b[s+6+4*w], f.b[s+5+4*w], f.b[s+4+4*w], f.b[s+3+4*w]});
  endtask
  // loader-owned write cycles are matched in order against the expected queue
  always @(negedge clk)
    if (rstb && busy && ram_if.en) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: addr %0h data %0h, no write expected", ram_if.addr, ram_if.wdata);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        check("wr_addr", int'(ram_if.addr), int'(e[35:32]));
        check("wr_data", int'(ram_if.wdata), int'(e[31:0]));
        check("wr_we", int'(ram_if.we), 15);
      end
    end
  initial begin
    rstb = 1'b0;
    req_b = 1'b1;
    rx_v = 1'b0;
    rx_d = 8'h00;
    core_if.en = 1'b0;
    core_if.we = 4'h0;
    core_if.addr = 4'd7;
    core_if.wdata = 32'h0;
    add("basic", 1, 2'd0, 1'b1, 96'hA501001122334455, 8);
    add("badcsum", 1, 2'd1, 1'b0, 96'hA501001122334456, 8);
    add("overflow", 0, 2'd2, 1'b0, 96'hA51100, 3);
    add("b2b_2word", 0, 2'd0, 1'b1, 96'hA502000102030405060708DA, 12);
    add("zero_len", 0, 2'd0, 1'b1, 96'hA5000000, 4);
    add("junk_sync", 1, 2'd0, 1'b1, 96'h1234A50100DEADBEEFC7, 10);
    v = tbl[0];
    v.name = "max_len";
    v.n = 68;
    v.gap = 0;
    v.err = 2'd0;
    v.done = 1'b1;
    v.b[0] = 8'hA5;
    v.b[1] = 8'h10;
    v.b[2] = 8'h00;
    for (int i = 0; i < 64; i++) v.b[3+i] = 8'(i);
    v.b[67] = 8'h10;
    tbl.push_back(v);
    tick(2);
    check("rst_core_rstb", int'(core_rstb), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_passthru_addr", int'(ram_if.addr), 7);
    rstb = 1'b1;
    #1;
    check("release_core_rstb_0", int'(core_rstb), 0);
    tick(1);
    check("release_core_rstb_1", int'(core_rstb), 1);
    core_if.en = 1'b1;
    core_if.we = 4'hF;
    core_if.addr = 4'd5;
    core_if.wdata = 32'hDEADBEEF;
    #1;
    check("idle_pass_en", int'(ram_if.en), 1);
    check("idle_pass_we", int'(ram_if.we), 15);
    check("idle_pass_addr", int'(ram_if.addr), 5);
    check("idle_pass_wdata", int'(ram_if.wdata), int'(32'hDEADBEEF));
    core_if.en = 1'b0;
    core_if.we = 4'h0;
    tick(1);
    foreach (tbl[i]) begin
      v = tbl[i];
      req_b = 1'b1;
      tick(2);
      check({v.name, "_idle_core_rstb"}, int'(core_rstb), 1);
      check({v.name, "_idle_busy"}, int'(busy), 0);
      push_frame(v);
      req_b = 1'b0;
      tick(1);
      check({v.name, "_entry_busy"}, int'(busy), 1);
      check({v.name, "_entry_core_rstb"}, int'(core_rstb), 0);
      check({v.name, "_entry_done"}, int'(done), 0);
      check({v.name, "_entry_err"}, int'(err), 0);
      for (int j = 0; j < v.n; j++) begin
        send(v.b[j]);
        if (v.gap > 0) tick(v.gap);
      end
      tick(3);
      check({v.name, "_done"}, int'(done), int'(v.done));
      check({v.name, "_err"}, int'(err), int'(v.err));
      check({v.name, "_core_rstb"}, int'(core_rstb), int'(v.done));
      check({v.name, "_busy"}, int'(busy), int'(!v.done));
      check({v.name, "_writes_left"}, exp_q.size(), 0);
      req_b = 1'b1;
      tick(2);
      check({v.name, "_sticky_err"}, int'(err), int'(v.err));
      check({v.name, "_sticky_done"}, int'(done), int'(v.done));
      check({v.name, "_back_idle"}, int'(busy), 0);
    end
    req_b = 1'b0;
    tick(1);
    send(8'hA5); send(8'h02); send(8'h00); send(8'hAA);
    tick(15);
    check("to_before", int'(err), 0);
    tick(1);
    check("to_fire_err", int'(err), 3);
    check("to_fire_core_rstb", int'(core_rstb), 0);
    check("to_fire_busy", int'(busy), 1);
    req_b = 1'b1;
    tick(2);
    exp_q.push_back({4'd0, 32'hDDCCBBAA});
    exp_q.push_back({4'd1, 32'h04030201});
    req_b = 1'b0;
    tick(1);
    send(8'hA5); send(8'h02); send(8'h00); send(8'hAA);
    tick(15);
    send(8'hBB); send(8'hCC); send(8'hDD);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'hE6);
    tick(3);
    check("to_rescue_err", int'(err), 0);
    check("to_rescue_done", int'(done), 1);
    check("to_rescue_writes_left", exp_q.size(), 0);
    tick(5);
    send(8'hA5); send(8'h01);
    tick(3);
    check("done_hold_done", int'(done), 1);
    check("done_hold_busy", int'(busy), 0);
    check("done_hold_core_rstb", int'(core_rstb), 1);
    req_b = 1'b1;
    tick(2);
    exp_q.push_back({4'd0, 32'h44332211});
    req_b = 1'b0;
    tick(1);
    send(8'hA5); send(8'h01); send(8'h00); send(8'h11);
    core_if.en = 1'b1;
    core_if.we = 4'hF;
    core_if.addr = 4'd9;
    #1;
    check("data_arb_en", int'(ram_if.en), 0);
    check("data_arb_we", int'(ram_if.we), 0);
    send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    tick(2);
    check("data_arb_done", int'(done), 1);
    check("data_arb_writes_left", exp_q.size(), 0);
    req_b = 1'b1;
    tick(2);
    req_b = 1'b0;
    tick(1);
    send(8'hA5); send(8'h02); send(8'h00); send(8'h11); send(8'h22);
    #3;
    rstb = 1'b0;
    #1;
    check("async_core_rstb", int'(core_rstb), 0);
    check("async_busy", int'(busy), 0);
    check("async_passthru_addr", int'(ram_if.addr), 9);
    req_b = 1'b1;
    tick(1);
    rstb = 1'b1;
    tick(2);
    check("async_release", int'(core_rstb), 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
